// File: rtl/cpu_memory_stage_pkg.sv
// Shared types for the memory stage.
//   execute_data_t : bundle handed over by execute (strobe-toggle valid)
//   memory_data_t  : bundle handed to writeback (strobe-toggle valid)
//   mem_state_t    : memory stage FSM states
//   MW_BYTE/MW_HALF/MW_WORD : mem_width encodings
package cpu_memory_stage_pkg;

   localparam logic [2:0] MW_BYTE = 3'd1;
   localparam logic [2:0] MW_HALF = 3'd2;
   localparam logic [2:0] MW_WORD = 3'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  inst_rd;
      logic [31:0] rd;           // ALU result, forwarded for pass-through ops
      logic [31:0] rs2;          // store data
      logic [31:0] mem_address;
      logic        mem_read;
      logic        mem_write;
      logic        mem_flush;
      logic        mem_signed;
      logic [2:0]  mem_width;
      logic        strobe;
   } execute_data_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  inst_rd;
      logic [31:0] rd;
      logic        strobe;
   } memory_data_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_FLUSH
   } mem_state_t;

   // Builds the next writeback word; toggling the strobe is what marks it new.
   function automatic memory_data_t retire_result(input logic [31:0] pc,
                                                  input logic [4:0]  inst_rd,
                                                  input logic [31:0] rd,
                                                  input logic        prev_strobe);
      memory_data_t r;
      r.pc      = pc;
      r.inst_rd = inst_rd;
      r.rd      = rd;
      r.strobe  = ~prev_strobe;
      return r;
   endfunction

endpackage

// File: rtl/cpu_memory_align.sv
// Combinational lane handling for the memory stage; holds no state.
//   acc_offset/acc_width/store_data -> byte_en, wdata, misaligned
//      (the access currently offered by execute)
//   load_offset/load_width/load_signed/rdata -> load_value
//      (the load in flight, using its latched attributes)
module cpu_memory_align
   import cpu_memory_stage_pkg::*;
(
   input  logic [1:0]  acc_offset,
   input  logic [2:0]  acc_width,
   input  logic [31:0] store_data,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata,
   output logic        misaligned,
   input  logic [1:0]  load_offset,
   input  logic [2:0]  load_width,
   input  logic        load_signed,
   input  logic [31:0] rdata,
   output logic [31:0] load_value
);

   logic [31:0] lane;

   always_comb begin
      misaligned = ((acc_width == MW_HALF) && acc_offset[0]) ||
                   ((acc_width == MW_WORD) && (acc_offset != 2'd0));
      case (acc_width)
         MW_BYTE: begin
            byte_en = 4'b0001 << acc_offset;
            wdata   = {4{store_data[7:0]}};
         end
         MW_HALF: begin
            byte_en = 4'b0011 << acc_offset;
            wdata   = {2{store_data[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            wdata   = store_data;
         end
      endcase
   end

   always_comb begin
      lane = rdata >> {load_offset, 3'b000};
      case (load_width)
         MW_BYTE: load_value = {{24{load_signed & lane[7]}}, lane[7:0]};
         MW_HALF: load_value = {{16{load_signed & lane[15]}}, lane[15:0]};
         default: load_value = lane;
      endcase
   end

endmodule

// File: rtl/cpu_memory_stage.sv
// Memory pipeline stage between execute and writeback.
// Ports:
//   i_reset, i_clock              async active-high reset, clock
//   i_data / o_busy               execute handshake (strobe toggle, busy back)
//   o_bus_*, i_bus_rdata/ready    data bus: level request, one-cycle ready
//   o_flush_request/i_flush_ready cache flush handshake
//   o_data                        result to writeback (strobe toggle)
//   o_fault                       sticky: misaligned access or bus timeout
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a new input; pass-through and misaligned ops retire here
// ST_READ  | load request on the bus, waiting for i_bus_ready
// ST_WRITE | store request on the bus, waiting for i_bus_ready
// ST_FLUSH | flush request held, waiting for i_flush_ready
module cpu_memory_stage
   import cpu_memory_stage_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 1024
) (
   input  logic          i_reset,
   input  logic          i_clock,
   output logic          o_fault,
   input  execute_data_t i_data,
   output logic          o_busy,
   output logic          o_bus_request,
   output logic          o_bus_rw,
   output logic [31:0]   o_bus_address,
   output logic [3:0]    o_bus_byte_en,
   output logic [31:0]   o_bus_wdata,
   input  logic [31:0]   i_bus_rdata,
   input  logic          i_bus_ready,
   output logic          o_flush_request,
   input  logic          i_flush_ready,
   output memory_data_t  o_data
);

   localparam int unsigned TIMER_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(BUS_TIMEOUT - 1);

   mem_state_t         state;
   logic               last_strobe;
   logic [TIMER_W-1:0] timer;
   logic [31:0]        req_pc;
   logic [4:0]         req_inst_rd;
   logic [1:0]         req_offset;
   logic [2:0]         req_width;
   logic               req_signed;
   logic               req_flush;

   logic               pending;
   logic               is_mem;
   logic               timed_out;
   logic [3:0]         byte_en;
   logic [31:0]        wdata;
   logic               misaligned;
   logic [31:0]        load_value;

   assign pending   = (i_data.strobe != last_strobe);
   assign is_mem    = i_data.mem_read | i_data.mem_write | i_data.mem_flush;
   assign o_busy    = pending && !((state == ST_IDLE) && !is_mem);
   // Down-counter reaches zero on the last allowed waiting cycle.
   assign timed_out = (BUS_TIMEOUT != 0) && (timer == '0);

   cpu_memory_align u_align (
      .acc_offset  (i_data.mem_address[1:0]),
      .acc_width   (i_data.mem_width),
      .store_data  (i_data.rs2),
      .byte_en     (byte_en),
      .wdata       (wdata),
      .misaligned  (misaligned),
      .load_offset (req_offset),
      .load_width  (req_width),
      .load_signed (req_signed),
      .rdata       (i_bus_rdata),
      .load_value  (load_value)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state           <= ST_IDLE;
         last_strobe     <= 1'b0;
         timer           <= '0;
         req_pc          <= '0;
         req_inst_rd     <= '0;
         req_offset      <= '0;
         req_width       <= '0;
         req_signed      <= 1'b0;
         req_flush       <= 1'b0;
         o_fault         <= 1'b0;
         o_bus_request   <= 1'b0;
         o_bus_rw        <= 1'b0;
         o_bus_address   <= '0;
         o_bus_byte_en   <= '0;
         o_bus_wdata     <= '0;
         o_flush_request <= 1'b0;
         o_data          <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  if (!is_mem) begin
                     o_data      <= retire_result(i_data.pc, i_data.inst_rd, i_data.rd, o_data.strobe);
                     last_strobe <= i_data.strobe;
                  end else if ((i_data.mem_read || i_data.mem_write) && misaligned) begin
                     o_fault     <= 1'b1;
                     o_data      <= retire_result(i_data.pc, 5'd0, 32'd0, o_data.strobe);
                     last_strobe <= i_data.strobe;
                  end else begin
                     timer       <= TIMER_LOAD;
                     req_pc      <= i_data.pc;
                     req_inst_rd <= i_data.inst_rd;
                     req_offset  <= i_data.mem_address[1:0];
                     req_width   <= i_data.mem_width;
                     req_signed  <= i_data.mem_signed;
                     req_flush   <= i_data.mem_flush;
                     if (i_data.mem_read) begin
                        o_bus_request <= 1'b1;
                        o_bus_rw      <= 1'b0;
                        o_bus_address <= {i_data.mem_address[31:2], 2'b00};
                        o_bus_byte_en <= 4'b0000;
                        state         <= ST_READ;
                     end else if (i_data.mem_write) begin
                        o_bus_request <= 1'b1;
                        o_bus_rw      <= 1'b1;
                        o_bus_address <= {i_data.mem_address[31:2], 2'b00};
                        o_bus_byte_en <= byte_en;
                        o_bus_wdata   <= wdata;
                        state         <= ST_WRITE;
                     end else begin
                        o_flush_request <= 1'b1;
                        state           <= ST_FLUSH;
                     end
                  end
               end
            end

            ST_READ: begin
               if (i_bus_ready) begin
                  o_bus_request <= 1'b0;
                  o_data        <= retire_result(req_pc, req_inst_rd, load_value, o_data.strobe);
                  last_strobe   <= i_data.strobe;
                  state         <= ST_IDLE;
               end else if (timed_out) begin
                  o_fault       <= 1'b1;
                  o_bus_request <= 1'b0;
                  o_data        <= retire_result(req_pc, 5'd0, 32'd0, o_data.strobe);
                  last_strobe   <= i_data.strobe;
                  state         <= ST_IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            ST_WRITE: begin
               if (i_bus_ready) begin
                  o_bus_request <= 1'b0;
                  if (req_flush) begin
                     // store+flush: the flush gets its own timeout window
                     o_flush_request <= 1'b1;
                     timer           <= TIMER_LOAD;
                     state           <= ST_FLUSH;
                  end else begin
                     o_data      <= retire_result(req_pc, 5'd0, 32'd0, o_data.strobe);
                     last_strobe <= i_data.strobe;
                     state       <= ST_IDLE;
                  end
               end else if (timed_out) begin
                  o_fault       <= 1'b1;
                  o_bus_request <= 1'b0;
                  o_data        <= retire_result(req_pc, 5'd0, 32'd0, o_data.strobe);
                  last_strobe   <= i_data.strobe;
                  state         <= ST_IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            ST_FLUSH: begin
               if (i_flush_ready || timed_out) begin
                  if (!i_flush_ready) begin
                     o_fault <= 1'b1;
                  end
                  o_flush_request <= 1'b0;
                  o_data          <= retire_result(req_pc, 5'd0, 32'd0, o_data.strobe);
                  last_strobe     <= i_data.strobe;
                  state           <= ST_IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_memory_stage.sv
module tb_cpu_memory_stage;
   import cpu_memory_stage_pkg::*;

   logic          i_reset;
   logic          i_clock;
   logic          o_fault;
   execute_data_t i_data;
   logic          o_busy;
   logic          o_bus_request;
   logic          o_bus_rw;
   logic [31:0]   o_bus_address;
   logic [3:0]    o_bus_byte_en;
   logic [31:0]   o_bus_wdata;
   logic [31:0]   i_bus_rdata;
   logic          i_bus_ready;
   logic          o_flush_request;
   logic          i_flush_ready;
   memory_data_t  o_data;

   int n_checks = 0;
   int n_fail   = 0;
   logic exp_strobe;
   logic exp_fault;

   cpu_memory_stage #(.BUS_TIMEOUT(8)) dut (
      .i_reset         (i_reset),
      .i_clock         (i_clock),
      .o_fault         (o_fault),
      .i_data          (i_data),
      .o_busy          (o_busy),
      .o_bus_request   (o_bus_request),
      .o_bus_rw        (o_bus_rw),
      .o_bus_address   (o_bus_address),
      .o_bus_byte_en   (o_bus_byte_en),
      .o_bus_wdata     (o_bus_wdata),
      .i_bus_rdata     (i_bus_rdata),
      .i_bus_ready     (i_bus_ready),
      .o_flush_request (o_flush_request),
      .i_flush_ready   (i_flush_ready),
      .o_data          (o_data)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   // Reference arithmetic for a load: pick the addressed lane, then extend.
   function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                              input int width, input logic sgn);
      logic [31:0] v;
      v = rdata >> (8 * off);
      if (width == 1) begin
         v = v % 256;
         if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (width == 2) begin
         v = v % 65536;
         if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [3:0] model_be(input int off, input int width);
      if (width == 4) return 4'd15;
      return 4'(((1 << width) - 1) << off);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] d, input int width);
      if (width == 1) return (d % 256) * 32'h0101_0101;
      if (width == 2) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   task automatic do_reset();
      i_data        = '0;
      i_bus_ready   = 1'b0;
      i_flush_ready = 1'b0;
      i_bus_rdata   = '0;
      i_reset       = 1'b1;
      repeat (2) tick();
      i_reset    = 1'b0;
      exp_strobe = 1'b0;
      exp_fault  = 1'b0;
      tick();
   endtask

   // Presents one instruction, plays the bus/flush side and checks the outcome.
   task automatic do_op(input logic rd_f, input logic wr_f, input logic fl_f,
                        input int width, input logic sgn, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rd, input logic [31:0] pc,
                        input logic [4:0] ird, input logic [31:0] rdata,
                        input int d_bus, input int d_fl);
      execute_data_t ed;
      logic is_mem;
      logic mis;
      int off;
      off           = int'(addr % 4);
      ed            = '0;
      ed.pc         = pc;
      ed.inst_rd    = ird;
      ed.rd         = rd;
      ed.rs2        = rs2;
      ed.mem_address= addr;
      ed.mem_read   = rd_f;
      ed.mem_write  = wr_f;
      ed.mem_flush  = fl_f;
      ed.mem_signed = sgn;
      ed.mem_width  = 3'(width);
      ed.strobe     = ~i_data.strobe;
      i_data        = ed;
      is_mem = rd_f | wr_f | fl_f;
      mis    = (rd_f | wr_f) && ((width == 2 && off % 2 == 1) || (width == 4 && off != 0));
      #1 check("busy_on_new", 32'(o_busy), 32'(is_mem));
      tick();
      if (!is_mem) begin
         exp_strobe = ~exp_strobe;
         check("pt_rd", o_data.rd, rd);
         check("pt_inst_rd", 32'(o_data.inst_rd), 32'(ird));
         check("pt_pc", o_data.pc, pc);
         check("pt_strobe", 32'(o_data.strobe), 32'(exp_strobe));
         check("pt_busy", 32'(o_busy), 0);
         check("pt_no_req", 32'(o_bus_request), 0);
         return;
      end
      if (mis) begin
         exp_fault  = 1'b1;
         exp_strobe = ~exp_strobe;
         check("mis_fault", 32'(o_fault), 1);
         check("mis_strobe", 32'(o_data.strobe), 32'(exp_strobe));
         check("mis_inst_rd", 32'(o_data.inst_rd), 0);
         check("mis_no_req", 32'(o_bus_request), 0);
         check("mis_busy", 32'(o_busy), 0);
         return;
      end
      if (rd_f | wr_f) begin
         check("bus_req", 32'(o_bus_request), 1);
         check("bus_rw", 32'(o_bus_rw), 32'(wr_f));
         check("bus_addr", o_bus_address, (addr / 4) * 4);
         if (wr_f) begin
            check("bus_be", 32'(o_bus_byte_en), 32'(model_be(off, width)));
            check("bus_wdata", o_bus_wdata, model_wdata(rs2, width));
         end
         for (int i = 0; i < d_bus; i++) begin
            tick();
            check("busy_wait", 32'(o_busy), 1);
            check("req_held", 32'(o_bus_request), 1);
         end
         i_bus_rdata = rdata;
         i_bus_ready = 1'b1;
         tick();
         i_bus_ready = 1'b0;
         i_bus_rdata = $urandom;
         check("req_drop", 32'(o_bus_request), 0);
         if (rd_f) begin
            exp_strobe = ~exp_strobe;
            check("ld_rd", o_data.rd, model_load(rdata, off, width, sgn));
            check("ld_inst_rd", 32'(o_data.inst_rd), 32'(ird));
            check("ld_pc", o_data.pc, pc);
            check("ld_strobe", 32'(o_data.strobe), 32'(exp_strobe));
            check("ld_busy", 32'(o_busy), 0);
            check("ld_fault", 32'(o_fault), 32'(exp_fault));
            return;
         end
      end
      if (fl_f) begin
         check("fl_req", 32'(o_flush_request), 1);
         check("fl_no_bus", 32'(o_bus_request), 0);
         check("fl_busy", 32'(o_busy), 1);
         for (int i = 0; i < d_fl; i++) tick();
         i_flush_ready = 1'b1;
         tick();
         i_flush_ready = 1'b0;
         check("fl_drop", 32'(o_flush_request), 0);
      end
      exp_strobe = ~exp_strobe;
      check("nw_strobe", 32'(o_data.strobe), 32'(exp_strobe));
      check("nw_inst_rd", 32'(o_data.inst_rd), 0);
      check("nw_pc", o_data.pc, pc);
      check("nw_busy", 32'(o_busy), 0);
      check("nw_fault", 32'(o_fault), 32'(exp_fault));
   endtask

   initial begin
      int cnt;
      i_data = '0;
      i_bus_ready = 1'b0;
      i_flush_ready = 1'b0;
      i_bus_rdata = '0;
      i_reset = 1'b1;
      #2;
      check("rst_req", 32'(o_bus_request), 0);
      check("rst_odata_rd", o_data.rd, 0);
      check("rst_odata_strobe", 32'(o_data.strobe), 0);
      check("rst_fault", 32'(o_fault), 0);
      do_reset();
      check("rst_busy", 32'(o_busy), 0);

      // directed: pass-through, LB signed, SH
      do_op(0, 0, 0, 4, 0, 32'h0, 32'h0, 32'h0000_1234, 32'h0000_0100, 5'd7, 32'h0, 0, 0);
      do_op(1, 0, 0, 1, 1, 32'h0000_1003, 32'h0, 32'h0, 32'h0000_0104, 5'd9, 32'h80FF_FFFF, 3, 0);
      do_op(0, 1, 0, 2, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 32'h0000_0108, 5'd3, 32'h0, 1, 0);

      // randomized mix
      for (int n = 0; n < 60; n++) begin
         int kind, wsel, width, off;
         logic [31:0] addr;
         kind  = int'($urandom_range(0, 8));
         wsel  = int'($urandom_range(0, 2));
         width = (wsel == 0) ? 1 : (wsel == 1) ? 2 : 4;
         off   = (width == 1) ? int'($urandom_range(0, 3)) :
                 (width == 2) ? 2 * int'($urandom_range(0, 1)) : 0;
         addr  = $urandom;
         addr  = (addr / 4) * 4 + 32'(off);
         case (kind)
            0: do_op(0, 0, 0, width, 0, addr, $urandom, $urandom, $urandom, 5'($urandom), 32'h0, 0, 0);
            1, 2, 3: do_op(1, 0, 0, width, 1'($urandom), addr, $urandom, $urandom, $urandom,
                           5'($urandom), $urandom, int'($urandom_range(0, 5)), 0);
            4, 5: do_op(0, 1, 0, width, 0, addr, $urandom, $urandom, $urandom, 5'($urandom),
                        32'h0, int'($urandom_range(0, 5)), 0);
            6: do_op(0, 0, 1, width, 0, addr, $urandom, $urandom, $urandom, 5'($urandom),
                     32'h0, 0, int'($urandom_range(0, 5)));
            7: do_op(0, 1, 1, width, 0, addr, $urandom, $urandom, $urandom, 5'($urandom),
                     32'h0, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            default: begin
               i_bus_rdata = $urandom;
               i_bus_ready = 1'b1;
               tick();
               i_bus_ready = 1'b0;
               check("idle_ready_strobe", 32'(o_data.strobe), 32'(exp_strobe));
               check("idle_ready_req", 32'(o_bus_request), 0);
            end
         endcase
      end

      // misaligned LW
      do_op(1, 0, 0, 4, 0, 32'h0000_3001, 32'h0, 32'h0, 32'h0000_0200, 5'd5, 32'h0, 0, 0);

      // bus timeout with ready never asserted
      do_reset();
      check("rst_fault_clear", 32'(o_fault), 0);
      i_data             = '0;
      i_data.pc          = 32'h0000_0300;
      i_data.inst_rd     = 5'd4;
      i_data.mem_address = 32'h0000_5000;
      i_data.mem_read    = 1'b1;
      i_data.mem_width   = MW_WORD;
      i_data.strobe      = 1'b1;
      tick();
      cnt = 0;
      for (int i = 0; i < 20 && o_bus_request; i++) begin
         cnt++;
         tick();
      end
      exp_strobe = ~exp_strobe;
      check("to_req_cycles", 32'(cnt), 8);
      check("to_fault", 32'(o_fault), 1);
      check("to_req_low", 32'(o_bus_request), 0);
      check("to_busy", 32'(o_busy), 0);
      check("to_strobe", 32'(o_data.strobe), 32'(exp_strobe));
      check("to_inst_rd", 32'(o_data.inst_rd), 0);

      // reset during READ, then a late ready
      do_reset();
      do_op(0, 0, 0, 4, 0, 32'h0, 32'h0, 32'h0000_5555, 32'h0000_0400, 5'd2, 32'h0, 0, 0);
      do_op(1, 0, 0, 4, 0, 32'h0000_6000, 32'h0, 32'h0, 32'h0000_0404, 5'd6, 32'h0, 0, 0);
      // the load above retired; start another and reset it mid-flight
      i_data             = '0;
      i_data.pc          = 32'h0000_0408;
      i_data.inst_rd     = 5'd8;
      i_data.mem_address = 32'h0000_7000;
      i_data.mem_read    = 1'b1;
      i_data.mem_width   = MW_WORD;
      i_data.strobe      = ~exp_strobe;
      tick();
      check("rr_req_before", 32'(o_bus_request), 1);
      #2;
      i_reset = 1'b1;
      i_data  = '0;
      #1;
      check("rr_req_dropped", 32'(o_bus_request), 0);
      check("rr_odata_rd", o_data.rd, 0);
      check("rr_odata_pc", o_data.pc, 0);
      check("rr_odata_strobe", 32'(o_data.strobe), 0);
      tick();
      i_reset = 1'b0;
      tick();
      i_bus_rdata = 32'hDEAD_BEEF;
      i_bus_ready = 1'b1;
      tick();
      i_bus_ready = 1'b0;
      check("rr_late_rd", o_data.rd, 0);
      check("rr_late_strobe", 32'(o_data.strobe), 0);
      check("rr_late_req", 32'(o_bus_request), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
